// File: rtl/lsu_out.sv
// LSU response stage: a slot buffer that pairs in-order memory responses with request
// metadata, then aligns and extends load data and hands one result per request to writeback.
module lsu_out #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_type_i,
    input  logic        req_sign_ext_i,
    input  logic [1:0]  req_offset_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i,
    output logic        lsu_valid_o,
    input  logic        lsu_ready_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_we_o,
    output logic        lsu_err_o,
    output logic [3:0]  outstanding_o,
    output logic        rsp_unexpected_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic       we;
        logic [1:0] typ;
        logic       sign;
        logic [1:0] off;
    } meta_t;

    meta_t             meta_q [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [DEPTH-1:0]  err_q;
    logic [DEPTH-1:0]  alloc_q;
    logic [DEPTH-1:0]  filled_q;
    logic [PW-1:0]     head_q, fill_q, tail_q;
    logic [3:0]        count_q;
    logic              unexp_q;

    logic        issue, fill_ok, retire;
    meta_t       fm;
    logic        misal;
    logic [31:0] sh_byte, sh_half;
    logic [31:0] proc_data;
    logic        proc_err;

    // All handshake outputs derive from registered state (plus reset), never from rvalid/ready.
    assign req_ready_o      = rst_ni && (count_q < 4'(DEPTH));
    assign lsu_valid_o      = rst_ni && filled_q[head_q];
    assign lsu_rdata_o      = lsu_valid_o ? data_q[head_q] : 32'h0;
    assign lsu_we_o         = lsu_valid_o && meta_q[head_q].we;
    assign lsu_err_o        = lsu_valid_o && err_q[head_q];
    assign outstanding_o    = rst_ni ? count_q : 4'h0;
    assign rsp_unexpected_o = rst_ni && unexp_q;

    assign issue   = req_valid_i && req_ready_o;
    assign fill_ok = data_rvalid_i && alloc_q[fill_q] && !filled_q[fill_q];
    assign retire  = lsu_valid_o && lsu_ready_i;

    always_comb begin
        fm        = meta_q[fill_q];
        proc_data = 32'h0;
        proc_err  = 1'b0;
        sh_byte   = data_rdata_i >> {fm.off, 3'b000};
        sh_half   = data_rdata_i >> {fm.off[1], 4'b0000};
        misal     = ((fm.typ == 2'b00 || fm.typ == 2'b11) && fm.off != 2'b00) ||
                    (fm.typ == 2'b01 && fm.off[0]);
        if (data_err_i || misal) begin
            proc_err = 1'b1;
        end else if (!fm.we) begin
            unique case (fm.typ)
                2'b01:   proc_data = {{16{fm.sign & sh_half[15]}}, sh_half[15:0]};
                2'b10:   proc_data = {{24{fm.sign & sh_byte[7]}}, sh_byte[7:0]};
                default: proc_data = data_rdata_i;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q   <= '0;
            fill_q   <= '0;
            tail_q   <= '0;
            count_q  <= 4'h0;
            unexp_q  <= 1'b0;
            alloc_q  <= '0;
            filled_q <= '0;
            err_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                meta_q[i] <= '0;
                data_q[i] <= 32'h0;
            end
        end else begin
            if (issue) begin
                meta_q[tail_q]  <= '{we: req_we_i, typ: req_type_i, sign: req_sign_ext_i,
                                     off: req_offset_i};
                alloc_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PW'(1);
            end
            // A response arriving with no allocated-unfilled slot is dropped and flagged.
            if (fill_ok) begin
                data_q[fill_q]   <= proc_data;
                err_q[fill_q]    <= proc_err;
                filled_q[fill_q] <= 1'b1;
                fill_q           <= fill_q + PW'(1);
            end else if (data_rvalid_i) begin
                unexp_q <= 1'b1;
            end
            if (retire) begin
                alloc_q[head_q]  <= 1'b0;
                filled_q[head_q] <= 1'b0;
                head_q           <= head_q + PW'(1);
            end
            count_q <= count_q + 4'(issue) - 4'(retire);
        end
    end
endmodule

// File: tb/tb_lsu_out.sv
// Directed bench for lsu_out (DEPTH=2): hand-computed expectations for alignment,
// extension, errors, backpressure, occupancy limits and reset behaviour.
module tb_lsu_out;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i, req_ready_o, req_we_i, req_sign_ext_i;
    logic [1:0]  req_type_i, req_offset_i;
    logic        data_rvalid_i, data_err_i;
    logic [31:0] data_rdata_i;
    logic        lsu_valid_o, lsu_ready_i, lsu_we_o, lsu_err_o;
    logic [31:0] lsu_rdata_o;
    logic [3:0]  outstanding_o;
    logic        rsp_unexpected_o;

    int n_vec = 0;
    int n_bad = 0;

    lsu_out #(.DEPTH(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_type_i(req_type_i), .req_sign_ext_i(req_sign_ext_i), .req_offset_i(req_offset_i),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
        .lsu_valid_o(lsu_valid_o), .lsu_ready_i(lsu_ready_i), .lsu_rdata_o(lsu_rdata_o),
        .lsu_we_o(lsu_we_o), .lsu_err_o(lsu_err_o), .outstanding_o(outstanding_o),
        .rsp_unexpected_o(rsp_unexpected_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        req_valid_i = 0; req_we_i = 0; req_type_i = 2'b00; req_sign_ext_i = 0;
        req_offset_i = 2'b00; data_rvalid_i = 0; data_rdata_i = 32'h0; data_err_i = 0;
        lsu_ready_i = 0;
    endtask

    task automatic issue(input logic we, input logic [1:0] typ, input logic sgn,
                         input logic [1:0] off);
        req_valid_i = 1; req_we_i = we; req_type_i = typ; req_sign_ext_i = sgn;
        req_offset_i = off;
        cyc();
        req_valid_i = 0;
    endtask

    task automatic respond(input logic [31:0] d, input logic err);
        data_rvalid_i = 1; data_rdata_i = d; data_err_i = err;
        cyc();
        data_rvalid_i = 0; data_err_i = 0;
    endtask

    task automatic retire();
        lsu_ready_i = 1;
        cyc();
        lsu_ready_i = 0;
    endtask

    initial begin
        idle();
        rst_ni = 0;
        cyc(); cyc();
        check("rst_valid", 32'(lsu_valid_o), 32'h0);
        check("rst_ready", 32'(req_ready_o), 32'h0);
        check("rst_outst", 32'(outstanding_o), 32'h0);
        rst_ni = 1;
        #1;
        check("rel_ready", 32'(req_ready_o), 32'h1);

        // signed byte at offset 3
        issue(0, 2'b10, 1, 2'd3);
        check("byte_outst", 32'(outstanding_o), 32'h1);
        check("byte_nvalid", 32'(lsu_valid_o), 32'h0);
        respond(32'h80AB_CDEF, 0);
        check("byte_valid", 32'(lsu_valid_o), 32'h1);
        check("byte_data", lsu_rdata_o, 32'hFFFF_FF80);
        check("byte_err", 32'(lsu_err_o), 32'h0);
        retire();
        check("byte_retired", 32'(lsu_valid_o), 32'h0);
        check("byte_outst0", 32'(outstanding_o), 32'h0);

        // unsigned half, aligned then misaligned
        issue(0, 2'b01, 0, 2'd2);
        respond(32'h8001_1234, 0);
        check("half_data", lsu_rdata_o, 32'h0000_8001);
        check("half_err", 32'(lsu_err_o), 32'h0);
        retire();
        issue(0, 2'b01, 0, 2'd1);
        respond(32'h1234_5678, 0);
        check("halfmis_err", 32'(lsu_err_o), 32'h1);
        check("halfmis_data", lsu_rdata_o, 32'h0);
        retire();

        // signed half offset 0, unsigned byte offset 1
        issue(0, 2'b01, 1, 2'd0);
        respond(32'h0000_9ABC, 0);
        check("shalf_data", lsu_rdata_o, 32'hFFFF_9ABC);
        retire();
        issue(0, 2'b10, 0, 2'd1);
        respond(32'h0000_F100, 0);
        check("ubyte_data", lsu_rdata_o, 32'h0000_00F1);
        retire();

        // fill to DEPTH, then retire while full: no same-cycle bypass
        issue(0, 2'b00, 0, 2'd0);
        issue(0, 2'b00, 0, 2'd0);
        check("full_ready", 32'(req_ready_o), 32'h0);
        check("full_outst", 32'(outstanding_o), 32'h2);
        respond(32'hA5A5_A5A5, 0);
        lsu_ready_i = 1;
        #1;
        check("full_nobypass", 32'(req_ready_o), 32'h0);
        check("full_head", lsu_rdata_o, 32'hA5A5_A5A5);
        cyc();
        lsu_ready_i = 0;
        check("after_ready", 32'(req_ready_o), 32'h1);
        check("after_outst", 32'(outstanding_o), 32'h1);
        respond(32'h5A5A_5A5A, 0);
        retire();

        // backpressure holds head, then back-to-back retire
        issue(0, 2'b00, 0, 2'd0);
        issue(0, 2'b00, 0, 2'd0);
        respond(32'h1111_1111, 0);
        respond(32'h2222_2222, 0);
        check("bp_hold0", lsu_rdata_o, 32'h1111_1111);
        cyc();
        check("bp_hold1", lsu_rdata_o, 32'h1111_1111);
        check("bp_valid", 32'(lsu_valid_o), 32'h1);
        lsu_ready_i = 1;
        cyc();
        check("bp_next_valid", 32'(lsu_valid_o), 32'h1);
        check("bp_next_data", lsu_rdata_o, 32'h2222_2222);
        cyc();
        lsu_ready_i = 0;
        check("bp_drained", 32'(lsu_valid_o), 32'h0);
        check("bp_outst0", 32'(outstanding_o), 32'h0);

        // unexpected response, bus error, stores
        respond(32'hDEAD_BEEF, 0);
        check("unexp_flag", 32'(rsp_unexpected_o), 32'h1);
        check("unexp_novalid", 32'(lsu_valid_o), 32'h0);
        issue(0, 2'b00, 0, 2'd0);
        respond(32'hCAFE_F00D, 1);
        check("buserr_err", 32'(lsu_err_o), 32'h1);
        check("buserr_data", lsu_rdata_o, 32'h0);
        retire();
        issue(1, 2'b00, 0, 2'd0);
        respond(32'h1234_5678, 0);
        check("store_we", 32'(lsu_we_o), 32'h1);
        check("store_err", 32'(lsu_err_o), 32'h0);
        check("store_data", lsu_rdata_o, 32'h0);
        retire();
        issue(1, 2'b00, 0, 2'd2);
        respond(32'h1234_5678, 0);
        check("stmis_err", 32'(lsu_err_o), 32'h1);
        retire();
        check("unexp_sticky", 32'(rsp_unexpected_o), 32'h1);

        // reset mid-traffic drops slots; later response is unexpected
        issue(0, 2'b00, 0, 2'd0);
        issue(0, 2'b00, 0, 2'd0);
        respond(32'h7777_7777, 0);
        rst_ni = 0;
        #1;
        check("mrst_valid", 32'(lsu_valid_o), 32'h0);
        check("mrst_rdata", lsu_rdata_o, 32'h0);
        check("mrst_ready", 32'(req_ready_o), 32'h0);
        cyc(); cyc();
        check("mrst_outst", 32'(outstanding_o), 32'h0);
        check("mrst_unexp", 32'(rsp_unexpected_o), 32'h0);
        rst_ni = 1;
        #1;
        check("mrel_ready", 32'(req_ready_o), 32'h1);
        check("mrel_outst", 32'(outstanding_o), 32'h0);
        check("mrel_unexp", 32'(rsp_unexpected_o), 32'h0);
        respond(32'h8888_8888, 0);
        check("dropped_unexp", 32'(rsp_unexpected_o), 32'h1);
        check("dropped_novalid", 32'(lsu_valid_o), 32'h0);

        // response in the same cycle as issue cannot fill that slot
        data_rvalid_i = 1; data_rdata_i = 32'h9999_9999;
        issue(0, 2'b00, 0, 2'd0);
        data_rvalid_i = 0;
        check("sameissue_novalid", 32'(lsu_valid_o), 32'h0);
        check("sameissue_outst", 32'(outstanding_o), 32'h1);
        respond(32'h4444_4444, 0);
        check("sameissue_fill", lsu_rdata_o, 32'h4444_4444);
        retire();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
